// File: rtl/shifter_adc_reader.sv
// Avalon-MM master for the shifter ADC: starts single-cycle conversion sequences, waits for the
// sample-store interrupt, averages 2^SLOT_LOG2 slots and publishes the gear-lever position.
module shifter_adc_reader #(
    parameter int SLOT_LOG2      = 2,
    parameter int PERIOD_CYCLES  = 50000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clock_clk,
    input  logic        reset_sink_reset_n,
    input  logic        enable,
    input  logic        clear_err,
    output logic        sequencer_csr_address,
    output logic        sequencer_csr_read,
    output logic        sequencer_csr_write,
    output logic [31:0] sequencer_csr_writedata,
    input  logic [31:0] sequencer_csr_readdata,
    output logic [6:0]  sample_store_csr_address,
    output logic        sample_store_csr_read,
    output logic        sample_store_csr_write,
    output logic [31:0] sample_store_csr_writedata,
    input  logic [31:0] sample_store_csr_readdata,
    input  logic        sample_store_irq_irq,
    output logic [11:0] position_data,
    output logic        position_valid,
    output logic        timeout_err
);

    localparam int ACC_W   = 12 + SLOT_LOG2;
    localparam int CNT_MAX = (PERIOD_CYCLES > TIMEOUT_CYCLES) ? PERIOD_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]     PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [SLOT_LOG2-1:0] SLOT_LAST    = {SLOT_LOG2{1'b1}};

    localparam logic [6:0]  ADDR_IRQ_STATUS = 7'd65;
    localparam logic [6:0]  ADDR_IRQ_ENABLE = 7'd64;
    localparam logic [31:0] SEQ_RUN_SINGLE  = 32'h0000_0003;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IRQEN,
        ST_IDLE,
        ST_START,
        ST_WAIT_IRQ,
        ST_STOP,
        ST_READ,
        ST_CLEAR,
        ST_DONE,
        ST_HOLD
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 armed_q;
    logic [CNT_W-1:0]     cyc_cnt_q;
    logic [CNT_W-1:0]     cyc_cnt_inc;
    logic [SLOT_LOG2-1:0] slot_cnt_q;
    logic                 rd_pending_q;
    logic [ACC_W-1:0]     acc_q;
    logic [ACC_W-1:0]     acc_sum;
    logic                 unused_inputs;

    assign unused_inputs = ^{sequencer_csr_readdata, sample_store_csr_readdata[31:12]};

    assign cyc_cnt_inc = cyc_cnt_q + CNT_W'(1);
    assign acc_sum     = acc_q + ACC_W'(sample_store_csr_readdata[11:0]);

    // armed_q holds the INIT write off until the first clock after reset release,
    // so every output stays 0 while reset is asserted.
    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            state_q <= ST_INIT;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    // IRQEN and HOLD jump straight to START when enabled; IDLE is only the parking state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:     if (armed_q) state_d = ST_IRQEN;
            ST_IRQEN:    state_d = enable ? ST_START : ST_IDLE;
            ST_IDLE:     if (enable) state_d = ST_START;
            ST_START:    state_d = ST_WAIT_IRQ;
            ST_WAIT_IRQ: begin
                if (sample_store_irq_irq)             state_d = ST_READ;
                else if (cyc_cnt_inc == TIMEOUT_LAST) state_d = ST_STOP;
            end
            ST_STOP:     state_d = ST_HOLD;
            ST_READ:     if (slot_cnt_q == SLOT_LAST) state_d = ST_CLEAR;
            ST_CLEAR:    state_d = ST_DONE;
            ST_DONE:     state_d = ST_HOLD;
            ST_HOLD:     if (cyc_cnt_q == PERIOD_LAST) state_d = enable ? ST_START : ST_IDLE;
            default:     state_d = ST_INIT;
        endcase
    end

    // Bus timing: no waitrequest, every strobe is a single cycle, read data returns one cycle
    // after the read strobe, and address/writedata are forced to 0 whenever their strobe is low.
    always_comb begin
        sequencer_csr_address      = 1'b0;
        sequencer_csr_read         = 1'b0;
        sequencer_csr_write        = 1'b0;
        sequencer_csr_writedata    = 32'd0;
        sample_store_csr_address   = 7'd0;
        sample_store_csr_read      = 1'b0;
        sample_store_csr_write     = 1'b0;
        sample_store_csr_writedata = 32'd0;
        case (state_q)
            ST_INIT: begin
                if (armed_q) begin
                    sample_store_csr_write     = 1'b1;
                    sample_store_csr_address   = ADDR_IRQ_STATUS;
                    sample_store_csr_writedata = 32'd1;
                end
            end
            ST_IRQEN: begin
                sample_store_csr_write     = 1'b1;
                sample_store_csr_address   = ADDR_IRQ_ENABLE;
                sample_store_csr_writedata = 32'd1;
            end
            ST_START: begin
                sequencer_csr_write     = 1'b1;
                sequencer_csr_writedata = SEQ_RUN_SINGLE;
            end
            ST_STOP: begin
                sequencer_csr_write = 1'b1;
            end
            ST_READ: begin
                sample_store_csr_read    = 1'b1;
                sample_store_csr_address = 7'(slot_cnt_q);
            end
            ST_CLEAR: begin
                sample_store_csr_write     = 1'b1;
                sample_store_csr_address   = ADDR_IRQ_STATUS;
                sample_store_csr_writedata = 32'd1;
            end
            default: begin
            end
        endcase
    end

    // One counter serves both the irq timeout and the inter-sequence period.
    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            cyc_cnt_q <= '0;
        end else if ((state_q == ST_WAIT_IRQ && !sample_store_irq_irq) || state_q == ST_HOLD) begin
            cyc_cnt_q <= cyc_cnt_inc;
        end else begin
            cyc_cnt_q <= '0;
        end
    end

    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            slot_cnt_q   <= '0;
            rd_pending_q <= 1'b0;
            acc_q        <= '0;
        end else begin
            slot_cnt_q   <= (state_q == ST_READ) ? slot_cnt_q + SLOT_LOG2'(1) : '0;
            rd_pending_q <= sample_store_csr_read;
            if (state_q == ST_WAIT_IRQ && sample_store_irq_irq) begin
                acc_q <= '0;
            end else if (rd_pending_q) begin
                acc_q <= acc_sum;
            end
        end
    end

    // The last slot lands during CLEAR, so the average is taken from acc_sum there and
    // presented together with the valid pulse in DONE.
    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            position_data  <= 12'd0;
            position_valid <= 1'b0;
        end else begin
            position_valid <= (state_q == ST_CLEAR);
            if (state_q == ST_CLEAR) begin
                position_data <= acc_sum[ACC_W-1:SLOT_LOG2];
            end
        end
    end

    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            timeout_err <= 1'b0;
        end else if (state_q == ST_STOP) begin
            timeout_err <= 1'b1;
        end else if (clear_err) begin
            timeout_err <= 1'b0;
        end
    end

endmodule
